mcpu_core_scoreboard: RTL and testbench
=======================================

// Module: mcpu_core_scoreboard
// PURPOSE
//  Producer of the sb2d_reg_scoreboard / sb2d_pred_scoreboard busy vectors consumed by decode's
//  dep_stall logic. Marks a GPR or predicate busy when a packet issues with rd_we/pred_we, and
//  clears it when that lane's writeback retires. Tracks all issue lanes of the core.
//  Also flags protocol violations: a double-set or a spurious clear.
// PARAMETERS
//  LANES      4   issue/writeback lanes per packet
//  NREGS      32  GPR count (5-bit register numbers)
//  NPREDS     3   writable predicates p0..p2; p3 is constant-true and never tracked
// PORTS
//  clkrst_core_clk       in   1            core clock
//  clkrst_core_rst_n     in   1            asynchronous active-low reset
//  pc2sb_issue           in   1            packet leaves decode this cycle (not stalled/killed)
//  pc2sb_rd_num          in   5*LANES      per-lane destination number; lane i = [5i+4:5i]
//  pc2sb_rd_we           in   LANES        per-lane GPR write at issue
//  pc2sb_pred_we         in   LANES        per-lane predicate write; pred index = rd_num[1:0]
//  wb2sb_valid           in   LANES        per-lane writeback retiring this cycle
//  wb2sb_rd_num          in   5*LANES      per-lane writeback destination
//  wb2sb_rd_we           in   LANES        retiring lane wrote a GPR
//  wb2sb_pred_we         in   LANES        retiring lane wrote a predicate
//  sb_flush              in   1            pipeline flush; all in-flight writers killed
//  sb2d_reg_scoreboard   out  NREGS        busy bit per GPR
//  sb2d_pred_scoreboard  out  NPREDS       busy bit per predicate
//  sb_idle               out  1            no bit set in either vector
//  sb_err                out  2            sticky {spurious_clear, double_set}
// BEHAVIOUR
//  Reset (async, rst_n=0): both scoreboard vectors = 0, sb_err = 0, sb_idle = 1. Reset mid-operation
//   drops all pending bits immediately.
//  All outputs are registered. An event in cycle N is visible in cycle N+1. There is no
//   combinational bypass from the issue or writeback inputs to the outputs.
//  Set: when pc2sb_issue=1, for each lane i:
//   - pc2sb_rd_we[i] sets reg bit pc2sb_rd_num[i].
//   - pc2sb_pred_we[i] sets pred bit rd_num[i][1:0]. Index 3 is ignored.
//   Lane inputs are ignored when pc2sb_issue=0.
//  Clear: for each lane i with wb2sb_valid[i]=1:
//   - wb2sb_rd_we[i] clears reg bit wb2sb_rd_num[i].
//   - wb2sb_pred_we[i] clears pred bit wb2sb_rd_num[i][1:0]. Index 3 is ignored.
//  Next-state order: next = (cur & ~clr_mask) | set_mask. When set and clear hit the same bit in
//   the same cycle, set wins: the old writer retires and the new writer is pending.
//  Flush: sb_flush=1 makes next state all-zero for both vectors. This overrides any same-cycle
//   set or clear. sb_err is unaffected by flush.
//  Multiple lanes setting the same bit in one cycle: bit set once, no error (decode forbids
//   this; it is not checked here).
//  double_set (sb_err[0]): sets if a set targets a bit already 1 in cur that is not being cleared
//   this cycle. Flush cycles are excluded.
//  spurious_clear (sb_err[1]): sets if a clear targets a bit that is 0 in cur. Flush cycles are
//   excluded.
//  sb_err bits are sticky until reset.
//  sb_idle = ~|{sb2d_reg_scoreboard, sb2d_pred_scoreboard}. It is combinational from the
//   registered state.
// TESTING
//  Reset then idle: all outputs 0, sb_idle=1.
//  Issue lane0 rd=5 rd_we; lane2 rd=2 pred_we (cycle N):
//   -> N+1: reg=32'h0000_0020, pred=3'b100, sb_idle=0.
//   WB lane1 rd=5 rd_we (cycle N+3) -> N+4: reg=0.
//  Same-cycle retire+reissue of r7: cur r7=1, wb clears r7, issue sets r7 -> r7 stays 1, sb_err=0.
//  Pred index 3: issue pred_we with rd_num=3 -> pred vector unchanged, no error.
//  Flush: regs r1,r9,p0 busy; assert sb_flush together with an issue to r4 ->
//   next cycle all 0, sb_idle=1.
//  Errors:
//   - Issue r3 twice with no WB between -> sb_err=2'b01.
//   - WB clear of idle r12 -> sb_err=2'b11.
//   - Both bits hold until rst_n pulses low mid-run; after that, all outputs return to reset values.

Source files
------------

// File: rtl/mcpu_core_scoreboard.sv
// Busy-bit scoreboard for GPRs and writable predicates across all issue lanes.
// Bits are set at issue and cleared at writeback, and protocol violations are flagged as sticky errors.
module mcpu_core_scoreboard #(
  parameter int LANES  = 4,
  parameter int NREGS  = 32,
  parameter int NPREDS = 3
) (
  input  logic               clkrst_core_clk,
  input  logic               clkrst_core_rst_n,
  input  logic               pc2sb_issue,
  input  logic [5*LANES-1:0] pc2sb_rd_num,
  input  logic [LANES-1:0]   pc2sb_rd_we,
  input  logic [LANES-1:0]   pc2sb_pred_we,
  input  logic [LANES-1:0]   wb2sb_valid,
  input  logic [5*LANES-1:0] wb2sb_rd_num,
  input  logic [LANES-1:0]   wb2sb_rd_we,
  input  logic [LANES-1:0]   wb2sb_pred_we,
  input  logic               sb_flush,
  output logic [NREGS-1:0]   sb2d_reg_scoreboard,
  output logic [NPREDS-1:0]  sb2d_pred_scoreboard,
  output logic               sb_idle,
  output logic [1:0]         sb_err
);

  logic [NREGS-1:0]  reg_set;
  logic [NREGS-1:0]  reg_clr;
  logic [NREGS-1:0]  reg_nxt;
  logic [NPREDS-1:0] pred_set;
  logic [NPREDS-1:0] pred_clr;
  logic [NPREDS-1:0] pred_nxt;
  logic              double_set;
  logic              spurious_clr;

  function automatic logic [NREGS-1:0] reg_onehot(input logic [4:0] num);
    reg_onehot = '0;
    if (int'(num) < NREGS) reg_onehot[num] = 1'b1;
  endfunction

  // Predicate index 3 is the constant-true predicate and never decodes to a bit.
  function automatic logic [NPREDS-1:0] pred_onehot(input logic [1:0] idx);
    pred_onehot = '0;
    if (int'(idx) < NPREDS) pred_onehot[idx] = 1'b1;
  endfunction

  always_comb begin
    reg_set  = '0;
    reg_clr  = '0;
    pred_set = '0;
    pred_clr = '0;
    for (int i = 0; i < LANES; i++) begin
      if (pc2sb_issue && pc2sb_rd_we[i])
        reg_set = reg_set | reg_onehot(pc2sb_rd_num[5*i +: 5]);
      if (pc2sb_issue && pc2sb_pred_we[i])
        pred_set = pred_set | pred_onehot(pc2sb_rd_num[5*i +: 2]);
      if (wb2sb_valid[i] && wb2sb_rd_we[i])
        reg_clr = reg_clr | reg_onehot(wb2sb_rd_num[5*i +: 5]);
      if (wb2sb_valid[i] && wb2sb_pred_we[i])
        pred_clr = pred_clr | pred_onehot(wb2sb_rd_num[5*i +: 2]);
    end
  end

  // Set wins over a same-cycle clear so a retire-and-reissue leaves the new writer pending.
  always_comb begin
    reg_nxt  = (sb2d_reg_scoreboard & ~reg_clr) | reg_set;
    pred_nxt = (sb2d_pred_scoreboard & ~pred_clr) | pred_set;
    if (sb_flush) begin
      reg_nxt  = '0;
      pred_nxt = '0;
    end
  end

  always_comb begin
    double_set   = 1'b0;
    spurious_clr = 1'b0;
    if (!sb_flush) begin
      double_set   = (|(reg_set & sb2d_reg_scoreboard & ~reg_clr)) |
                     (|(pred_set & sb2d_pred_scoreboard & ~pred_clr));
      spurious_clr = (|(reg_clr & ~sb2d_reg_scoreboard)) |
                     (|(pred_clr & ~sb2d_pred_scoreboard));
    end
  end

  always_ff @(posedge clkrst_core_clk or negedge clkrst_core_rst_n) begin
    if (!clkrst_core_rst_n) begin
      sb2d_reg_scoreboard  <= '0;
      sb2d_pred_scoreboard <= '0;
      sb_err               <= 2'b00;
    end else begin
      sb2d_reg_scoreboard  <= reg_nxt;
      sb2d_pred_scoreboard <= pred_nxt;
      sb_err               <= sb_err | {spurious_clr, double_set};
    end
  end

  assign sb_idle = ~|{sb2d_reg_scoreboard, sb2d_pred_scoreboard};

endmodule

// File: tb/tb_mcpu_core_scoreboard.sv
// Bench for mcpu_core_scoreboard: directed scenarios plus randomized traffic
// checked against a per-register busy model.
module tb_mcpu_core_scoreboard;

  localparam int LANES  = 4;
  localparam int NREGS  = 32;
  localparam int NPREDS = 3;

  logic                clk;
  logic                rst_n;
  logic                issue;
  logic [5*LANES-1:0]  rd_num;
  logic [LANES-1:0]    rd_we;
  logic [LANES-1:0]    pred_we;
  logic [LANES-1:0]    wb_valid;
  logic [5*LANES-1:0]  wb_rd_num;
  logic [LANES-1:0]    wb_rd_we;
  logic [LANES-1:0]    wb_pred_we;
  logic                flush;
  logic [NREGS-1:0]    reg_sb;
  logic [NPREDS-1:0]   pred_sb;
  logic                idle;
  logic [1:0]          err;

  int n_checks = 0;
  int n_fails  = 0;

  // Reference model: one busy flag per architectural register and predicate.
  bit       m_reg[NREGS];
  bit       m_pred[NPREDS];
  bit [1:0] m_err;

  mcpu_core_scoreboard #(.LANES(LANES), .NREGS(NREGS), .NPREDS(NPREDS)) dut (
    .clkrst_core_clk      (clk),
    .clkrst_core_rst_n    (rst_n),
    .pc2sb_issue          (issue),
    .pc2sb_rd_num         (rd_num),
    .pc2sb_rd_we          (rd_we),
    .pc2sb_pred_we        (pred_we),
    .wb2sb_valid          (wb_valid),
    .wb2sb_rd_num         (wb_rd_num),
    .wb2sb_rd_we          (wb_rd_we),
    .wb2sb_pred_we        (wb_pred_we),
    .sb_flush             (flush),
    .sb2d_reg_scoreboard  (reg_sb),
    .sb2d_pred_scoreboard (pred_sb),
    .sb_idle              (idle),
    .sb_err               (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive_idle();
    issue = 0; rd_num = '0; rd_we = '0; pred_we = '0;
    wb_valid = '0; wb_rd_num = '0; wb_rd_we = '0; wb_pred_we = '0;
    flush = 0;
  endtask

  task automatic set_issue(input int lane, input int num, input bit g, input bit p);
    issue = 1;
    rd_num[5*lane +: 5] = 5'(num);
    rd_we[lane] = g;
    pred_we[lane] = p;
  endtask

  task automatic set_wb(input int lane, input int num, input bit g, input bit p);
    wb_valid[lane] = 1;
    wb_rd_num[5*lane +: 5] = 5'(num);
    wb_rd_we[lane] = g;
    wb_pred_we[lane] = p;
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive_idle();
    rst_n = 0;
    tick();
    tick();
    rst_n = 1;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (reg_sb !== 32'h0) begin n_fails++; $display("[TB] FAIL reset_reg got=%h exp=%h", reg_sb, 32'h0); end
    n_checks++;
    if (pred_sb !== 3'b000) begin n_fails++; $display("[TB] FAIL reset_pred got=%b exp=000", pred_sb); end
    n_checks++;
    if (idle !== 1'b1) begin n_fails++; $display("[TB] FAIL reset_idle got=%b exp=1", idle); end
    n_checks++;
    if (err !== 2'b00) begin n_fails++; $display("[TB] FAIL reset_err got=%b exp=00", err); end
  endtask

  task automatic test_set_clear();
    drive_idle();
    set_issue(0, 5, 1, 0);
    set_issue(2, 2, 0, 1);
    #2;
    n_checks++;
    if (reg_sb !== 32'h0) begin n_fails++; $display("[TB] FAIL no_bypass got=%h exp=0", reg_sb); end
    tick();
    drive_idle();
    n_checks++;
    if (reg_sb !== 32'h0000_0020) begin n_fails++; $display("[TB] FAIL set_reg got=%h exp=00000020", reg_sb); end
    n_checks++;
    if (pred_sb !== 3'b100) begin n_fails++; $display("[TB] FAIL set_pred got=%b exp=100", pred_sb); end
    n_checks++;
    if (idle !== 1'b0) begin n_fails++; $display("[TB] FAIL set_idle got=%b exp=0", idle); end
    tick();
    tick();
    set_wb(1, 5, 1, 0);
    tick();
    drive_idle();
    n_checks++;
    if (reg_sb !== 32'h0) begin n_fails++; $display("[TB] FAIL wb_clear_reg got=%h exp=0", reg_sb); end
    n_checks++;
    if (pred_sb !== 3'b100) begin n_fails++; $display("[TB] FAIL wb_keep_pred got=%b exp=100", pred_sb); end
    set_wb(3, 2, 0, 1);
    tick();
    drive_idle();
    n_checks++;
    if (pred_sb !== 3'b000 || idle !== 1'b1) begin
      n_fails++; $display("[TB] FAIL wb_clear_pred got=%b/%b exp=000/1", pred_sb, idle);
    end
    n_checks++;
    if (err !== 2'b00) begin n_fails++; $display("[TB] FAIL set_clear_err got=%b exp=00", err); end
  endtask

  task automatic test_back_to_back();
    drive_idle();
    set_issue(0, 7, 1, 0);
    tick();
    drive_idle();
    set_wb(0, 7, 1, 0);
    set_issue(1, 7, 1, 0);
    tick();
    drive_idle();
    n_checks++;
    if (reg_sb !== 32'h0000_0080) begin n_fails++; $display("[TB] FAIL reissue_reg got=%h exp=00000080", reg_sb); end
    n_checks++;
    if (err !== 2'b00) begin n_fails++; $display("[TB] FAIL reissue_err got=%b exp=00", err); end
    set_wb(2, 7, 1, 0);
    tick();
    drive_idle();
    n_checks++;
    if (reg_sb !== 32'h0 || idle !== 1'b1) begin
      n_fails++; $display("[TB] FAIL reissue_retire got=%h/%b exp=0/1", reg_sb, idle);
    end
  endtask

  task automatic test_pred3();
    drive_idle();
    set_issue(1, 3, 0, 1);
    set_issue(3, 31, 0, 1);
    tick();
    drive_idle();
    n_checks++;
    if (pred_sb !== 3'b000 || idle !== 1'b1) begin
      n_fails++; $display("[TB] FAIL pred3_set got=%b/%b exp=000/1", pred_sb, idle);
    end
    set_wb(0, 3, 0, 1);
    tick();
    drive_idle();
    n_checks++;
    if (err !== 2'b00) begin n_fails++; $display("[TB] FAIL pred3_err got=%b exp=00", err); end
  endtask

  task automatic test_flush();
    drive_idle();
    set_issue(0, 1, 1, 0);
    set_issue(1, 9, 1, 0);
    set_issue(2, 0, 0, 1);
    tick();
    drive_idle();
    n_checks++;
    if (reg_sb !== 32'h0000_0202 || pred_sb !== 3'b001) begin
      n_fails++; $display("[TB] FAIL flush_pre got=%h/%b exp=00000202/001", reg_sb, pred_sb);
    end
    flush = 1;
    set_issue(0, 4, 1, 0);
    set_issue(1, 1, 1, 0);
    set_wb(0, 20, 1, 0);
    tick();
    drive_idle();
    n_checks++;
    if (reg_sb !== 32'h0 || pred_sb !== 3'b000 || idle !== 1'b1) begin
      n_fails++; $display("[TB] FAIL flush_clear got=%h/%b/%b exp=0/000/1", reg_sb, pred_sb, idle);
    end
    n_checks++;
    if (err !== 2'b00) begin n_fails++; $display("[TB] FAIL flush_err got=%b exp=00", err); end
  endtask

  task automatic test_errors();
    drive_idle();
    set_issue(0, 3, 1, 0);
    tick();
    tick();
    n_checks++;
    if (err !== 2'b01) begin n_fails++; $display("[TB] FAIL double_set got=%b exp=01", err); end
    drive_idle();
    set_wb(2, 12, 1, 0);
    tick();
    drive_idle();
    n_checks++;
    if (err !== 2'b11) begin n_fails++; $display("[TB] FAIL spurious_clear got=%b exp=11", err); end
    flush = 1;
    tick();
    drive_idle();
    tick();
    n_checks++;
    if (err !== 2'b11 || reg_sb !== 32'h0) begin
      n_fails++; $display("[TB] FAIL err_sticky got=%b/%h exp=11/0", err, reg_sb);
    end
    set_issue(0, 17, 1, 0);
    set_issue(1, 1, 0, 1);
    tick();
    drive_idle();
    #2;
    rst_n = 0;
    #1;
    n_checks++;
    if (reg_sb !== 32'h0 || pred_sb !== 3'b000 || idle !== 1'b1 || err !== 2'b00) begin
      n_fails++; $display("[TB] FAIL async_reset got=%h/%b/%b/%b exp=0/000/1/00", reg_sb, pred_sb, idle, err);
    end
    tick();
    rst_n = 1;
    tick();
  endtask

  // Advance the model by one cycle using the inputs currently driven.
  task automatic model_step();
    bit       nreg[NREGS];
    bit       npred[NPREDS];
    bit       s, c;
    for (int r = 0; r < NREGS; r++) begin
      s = 0; c = 0;
      for (int l = 0; l < LANES; l++) begin
        if (issue && rd_we[l] && int'(rd_num[5*l +: 5]) == r) s = 1;
        if (wb_valid[l] && wb_rd_we[l] && int'(wb_rd_num[5*l +: 5]) == r) c = 1;
      end
      if (!flush && s && m_reg[r] && !c) m_err[0] = 1;
      if (!flush && c && !m_reg[r]) m_err[1] = 1;
      nreg[r] = flush ? 1'b0 : (s || (m_reg[r] && !c));
    end
    for (int p = 0; p < NPREDS; p++) begin
      s = 0; c = 0;
      for (int l = 0; l < LANES; l++) begin
        if (issue && pred_we[l] && int'(rd_num[5*l +: 5]) % 4 == p) s = 1;
        if (wb_valid[l] && wb_pred_we[l] && int'(wb_rd_num[5*l +: 5]) % 4 == p) c = 1;
      end
      if (!flush && s && m_pred[p] && !c) m_err[0] = 1;
      if (!flush && c && !m_pred[p]) m_err[1] = 1;
      npred[p] = flush ? 1'b0 : (s || (m_pred[p] && !c));
    end
    m_reg = nreg;
    m_pred = npred;
  endtask

  task automatic test_random();
    logic [NREGS-1:0]  exp_reg;
    logic [NPREDS-1:0] exp_pred;
    int num;
    bit legal;
    do_reset();
    foreach (m_reg[r]) m_reg[r] = 0;
    foreach (m_pred[p]) m_pred[p] = 0;
    m_err = 2'b00;
    for (int cyc = 0; cyc < 400; cyc++) begin
      legal = (cyc < 250);
      drive_idle();
      issue = 1'($urandom_range(0, 1));
      for (int l = 0; l < LANES; l++) begin
        num = $urandom_range(0, 31);
        rd_num[5*l +: 5] = 5'(num);
        rd_we[l] = 1'($urandom_range(0, 2) == 0);
        pred_we[l] = 1'($urandom_range(0, 3) == 0);
        if (legal && m_reg[num]) rd_we[l] = 0;
        if (legal && (num % 4) < NPREDS && m_pred[num % 4]) pred_we[l] = 0;
        num = $urandom_range(0, 31);
        wb_rd_num[5*l +: 5] = 5'(num);
        wb_valid[l] = 1'($urandom_range(0, 1));
        wb_rd_we[l] = 1'($urandom_range(0, 1));
        wb_pred_we[l] = 1'($urandom_range(0, 2) == 0);
        if (legal && !m_reg[num]) wb_rd_we[l] = 0;
        if (legal && ((num % 4) >= NPREDS || !m_pred[num % 4])) wb_pred_we[l] = 0;
      end
      flush = 1'($urandom_range(0, 31) == 0);
      model_step();
      tick();
      for (int r = 0; r < NREGS; r++) exp_reg[r] = m_reg[r];
      for (int p = 0; p < NPREDS; p++) exp_pred[p] = m_pred[p];
      n_checks++;
      if (reg_sb !== exp_reg) begin
        n_fails++; $display("[TB] FAIL rand_reg cyc=%0d got=%h exp=%h", cyc, reg_sb, exp_reg);
      end
      n_checks++;
      if (pred_sb !== exp_pred) begin
        n_fails++; $display("[TB] FAIL rand_pred cyc=%0d got=%b exp=%b", cyc, pred_sb, exp_pred);
      end
      n_checks++;
      if (idle !== (exp_reg == '0 && exp_pred == '0)) begin
        n_fails++; $display("[TB] FAIL rand_idle cyc=%0d got=%b exp=%b", cyc, idle, (exp_reg == '0 && exp_pred == '0));
      end
      n_checks++;
      if (err !== m_err) begin
        n_fails++; $display("[TB] FAIL rand_err cyc=%0d got=%b exp=%b", cyc, err, m_err);
      end
    end
    drive_idle();
  endtask

  initial begin
    rst_n = 1;
    drive_idle();
    #3;
    test_reset();
    test_set_clear();
    test_back_to_back();
    test_pred3();
    test_flush();
    test_errors();
    test_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
